// File: rtl/data_memory_wait.sv
// MEM-stage data memory with a fixed access latency and a ready handshake.
// Out-of-range or misaligned byte addresses raise addr_err instead of aliasing into the array.
module data_memory_wait #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_W_EN,
    input  logic              MEM_R_EN,
    input  logic [31:0]       ALU_Res,
    input  logic [DATA_W-1:0] Val_Rm,
    output logic [DATA_W-1:0] out,
    output logic              ready,
    output logic              addr_err
);

    localparam logic [31:0] BPW   = 32'(DATA_W / 8);
    localparam logic [31:0] SPAN  = 32'(DEPTH * (DATA_W / 8));
    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               op_wr_r;
    logic [IDX_W-1:0]   idx_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               illegal_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               err_r;
    logic [DATA_W-1:0]  mem_r [DEPTH];

    logic               req_s;
    logic [31:0]        off_s;
    logic [31:0]        word_s;
    logic [IDX_W-1:0]   idx_s;
    logic               illegal_s;
    logic               capture_s;
    logic               commit_s;
    logic               acc_wr_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic [DATA_W-1:0]  acc_wdata_s;
    logic               acc_illegal_s;
    logic               unused_s;

    // The subtraction wraps below BASE_ADDR, so low addresses land in the out-of-range test.
    assign req_s     = MEM_W_EN | MEM_R_EN;
    assign off_s     = ALU_Res - BASE_ADDR;
    assign word_s    = off_s / BPW;
    assign idx_s     = word_s[IDX_W-1:0];
    assign illegal_s = (off_s >= SPAN) || ((off_s % BPW) != 32'd0);
    assign unused_s  = ^word_s;

    // Next-state, ready and commit decode.
    always_comb begin
        state_nxt_s = state_r;
        ready       = 1'b0;
        capture_s   = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready = ~req_s;
                if (req_s) begin
                    capture_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt_s = ST_DONE;
                        commit_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_DONE;
                    commit_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                ready       = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // With no wait cycles the commit edge is the capture edge, so use the live inputs then.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_wr_s      = MEM_W_EN;
            acc_idx_s     = idx_s;
            acc_wdata_s   = Val_Rm;
            acc_illegal_s = illegal_s;
        end else begin
            acc_wr_s      = op_wr_r;
            acc_idx_s     = idx_r;
            acc_wdata_s   = wdata_r;
            acc_illegal_s = illegal_r;
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                cnt_r <= CNT_LOAD;
            end else if ((state_r == ST_BUSY) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Request capture; a write wins when both enables are set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr_r   <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            illegal_r <= 1'b0;
        end else if (capture_s) begin
            op_wr_r   <= MEM_W_EN;
            idx_r     <= idx_s;
            wdata_r   <= Val_Rm;
            illegal_r <= illegal_s;
        end else begin
            op_wr_r   <= op_wr_r;
            idx_r     <= idx_r;
            wdata_r   <= wdata_r;
            illegal_r <= illegal_r;
        end
    end

    // Array, read data and error flag, updated on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_s) begin
            if (acc_illegal_s) begin
                rdata_r <= {DATA_W{1'b0}};
                err_r   <= 1'b1;
            end else if (acc_wr_s) begin
                mem_r[acc_idx_s] <= acc_wdata_s;
                err_r            <= 1'b0;
            end else begin
                rdata_r <= mem_r[acc_idx_s];
                err_r   <= 1'b0;
            end
        end
    end

    assign out      = ((state_r == ST_DONE) && !op_wr_r) ? rdata_r : {DATA_W{1'b0}};
    assign addr_err = (state_r == ST_DONE) && err_r;

endmodule

// File: tb/tb_data_memory_wait.sv
// Self-checking bench for data_memory_wait: directed scenarios plus random traffic
// against an address-keyed reference memory; a second instance covers the 64-bit/no-wait build.
module tb_data_memory_wait;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en, r_en;
    logic [31:0] alu_res, val_rm, out_d;
    logic        ready, addr_err;
    logic        w_en64, r_en64;
    logic [31:0] alu64;
    logic [63:0] val64, out64;
    logic        ready64, err64;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref32 [int];
    logic [63:0] ref64 [int];

    always #5 clk = ~clk;

    data_memory_wait dut (
        .clk(clk), .rst(rst), .MEM_W_EN(w_en), .MEM_R_EN(r_en), .ALU_Res(alu_res),
        .Val_Rm(val_rm), .out(out_d), .ready(ready), .addr_err(addr_err)
    );

    data_memory_wait #(.DATA_W(64), .DEPTH(16), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut64 (
        .clk(clk), .rst(rst), .MEM_W_EN(w_en64), .MEM_R_EN(r_en64), .ALU_Res(alu64),
        .Val_Rm(val64), .out(out64), .ready(ready64), .addr_err(err64)
    );

    // Reference: legal when inside [1024, 1024+span) and word aligned.
    function automatic bit legal(input logic [31:0] a, input int span, input int bpw);
        return (a >= 32'd1024) && (a < 32'(1024 + span)) && ((a % bpw) == 0);
    endfunction

    task automatic model32(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] eo, output logic ee);
        eo = 32'd0;
        ee = 1'b0;
        if (!legal(a, 256, 4)) ee = 1'b1;
        else if (w) ref32[int'(a)] = d;
        else if (r) eo = ref32.exists(int'(a)) ? ref32[int'(a)] : 32'd0;
    endtask

    task automatic model64(input logic w, input logic r, input logic [31:0] a, input logic [63:0] d,
                           output logic [63:0] eo, output logic ee);
        eo = 64'd0;
        ee = 1'b0;
        if (!legal(a, 128, 8)) ee = 1'b1;
        else if (w) ref64[int'(a)] = d;
        else if (r) eo = ref64.exists(int'(a)) ? ref64[int'(a)] : 64'd0;
    endtask

    // Drives one access from a negedge in IDLE; returns cycles with ready low (-1 on timeout),
    // the DONE-cycle outputs, and how often out/addr_err were nonzero while stalled.
    task automatic run32(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] o, output logic e, output int glitch);
        w_en = w; r_en = r; alu_res = a; val_rm = d;
        lat = 0;
        glitch = 0;
        #1;
        while (ready !== 1'b1 && lat < 20) begin
            if (out_d !== 32'd0 || addr_err !== 1'b0) glitch++;
            lat++;
            @(negedge clk);
            alu_res = $urandom;
            val_rm  = $urandom;
        end
        if (lat >= 20) lat = -1;
        o = out_d;
        e = addr_err;
        w_en = 1'b0; r_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run64(input logic w, input logic r, input logic [31:0] a, input logic [63:0] d,
                         output int lat, output logic [63:0] o, output logic e);
        w_en64 = w; r_en64 = r; alu64 = a; val64 = d;
        lat = 0;
        #1;
        while (ready64 !== 1'b1 && lat < 20) begin
            lat++;
            @(negedge clk);
            alu64 = $urandom;
        end
        if (lat >= 20) lat = -1;
        o = out64;
        e = err64;
        w_en64 = 1'b0; r_en64 = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ref32.delete();
        ref64.delete();
        #3;
    endtask

    task automatic test_reset();
        int lat, g;
        logic [31:0] o;
        logic e;
        n_checks++;
        if (ready !== 1'b1 || out_d !== 32'd0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b out=%h err=%b, expected 1/0/0", ready, out_d, addr_err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run32(1'b1, 1'b0, 32'd1024, 32'hA5A5_1234, lat, o, e, g);
        @(posedge clk);
        #2;
        do_reset();
        n_checks++;
        if (ready !== 1'b1 || out_d !== 32'd0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun: ready=%b out=%h err=%b, expected 1/0/0", ready, out_d, addr_err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run32(1'b0, 1'b1, 32'd1024, 32'd0, lat, o, e, g);
        n_checks++;
        if (o !== 32'd0 || lat !== WAIT + 1) begin
            n_fail++;
            $display("FAIL reset_read1024: out=%h lat=%0d, expected 0 lat=%0d", o, lat, WAIT + 1);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b1 || out_d !== 32'd0 || addr_err !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold: ready=%b out=%h err=%b, expected 1/0/0", ready, out_d, addr_err);
            end
        end
    endtask

    task automatic test_write_read();
        int lat, g;
        logic [31:0] o, eo;
        logic e, ee;
        model32(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, eo, ee);
        run32(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, lat, o, e, g);
        n_checks++;
        if (lat !== WAIT + 1 || o !== eo || e !== ee || g !== 0) begin
            n_fail++;
            $display("FAIL wr_1028: lat=%0d out=%h err=%b glitch=%0d, expected lat=%0d out=%h err=%b glitch=0",
                     lat, o, e, g, WAIT + 1, eo, ee);
        end
        model32(1'b0, 1'b1, 32'd1028, 32'd0, eo, ee);
        run32(1'b0, 1'b1, 32'd1028, 32'd0, lat, o, e, g);
        n_checks++;
        if (lat !== WAIT + 1 || o !== eo || e !== ee || g !== 0) begin
            n_fail++;
            $display("FAIL rd_1028: lat=%0d out=%h err=%b glitch=%0d, expected lat=%0d out=%h err=%b glitch=0",
                     lat, o, e, g, WAIT + 1, eo, ee);
        end
        n_checks++;
        if (out_d !== 32'd0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_after_done: out=%h ready=%b, expected 0/1", out_d, ready);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [10];
        logic        wr    [10];
        int lat, g;
        logic [31:0] o, eo, d;
        logic e, ee;
        addrs = '{32'd1024, 32'd1276, 32'd1280, 32'd1020, 32'd1026,
                  32'd1280, 32'd1020, 32'd1026, 32'd1024, 32'd1276};
        wr    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            model32(wr[i], !wr[i], addrs[i], d, eo, ee);
            run32(wr[i], !wr[i], addrs[i], d, lat, o, e, g);
            n_checks++;
            if (lat !== WAIT + 1 || o !== eo || e !== ee || g !== 0) begin
                n_fail++;
                $display("FAIL boundary_%0d addr=%0d: lat=%0d out=%h err=%b, expected lat=%0d out=%h err=%b",
                         i, addrs[i], lat, o, e, WAIT + 1, eo, ee);
            end
        end
    endtask

    task automatic test_simultaneous();
        int lat, g;
        logic [31:0] o, eo;
        logic e, ee;
        model32(1'b1, 1'b1, 32'd1032, 32'h55AA55AA, eo, ee);
        run32(1'b1, 1'b1, 32'd1032, 32'h55AA55AA, lat, o, e, g);
        n_checks++;
        if (o !== 32'd0 || e !== 1'b0 || lat !== WAIT + 1) begin
            n_fail++;
            $display("FAIL both_en: out=%h err=%b lat=%0d, expected 0/0/%0d", o, e, lat, WAIT + 1);
        end
        model32(1'b0, 1'b1, 32'd1032, 32'd0, eo, ee);
        run32(1'b0, 1'b1, 32'd1032, 32'd0, lat, o, e, g);
        n_checks++;
        if (o !== eo || e !== ee) begin
            n_fail++;
            $display("FAIL both_en_readback: out=%h err=%b, expected %h/%b", o, e, eo, ee);
        end
    endtask

    task automatic test_reset_busy();
        int lat, g;
        logic [31:0] o;
        logic e;
        w_en = 1'b1; r_en = 1'b0; alu_res = 32'd1036; val_rm = 32'h12345678;
        @(posedge clk);
        #2;
        do_reset();
        w_en = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || out_d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_busy_idle: ready=%b out=%h, expected 1/0", ready, out_d);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run32(1'b0, 1'b1, 32'd1036, 32'd0, lat, o, e, g);
        n_checks++;
        if (o !== 32'd0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_read1036: out=%h err=%b, expected 0/0", o, e);
        end
    endtask

    task automatic test_random();
        int lat, g, kind, op;
        logic [31:0] a, d, o, eo;
        logic e, ee, w, r;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4)      a = 32'd1024 + 32'd4 * $urandom_range(0, 7);
            else if (kind < 7) a = 32'd1024 + 32'd4 * $urandom_range(0, 63);
            else if (kind == 7) a = 32'd1024 + 32'd4 * $urandom_range(0, 63) + $urandom_range(1, 3);
            else if (kind == 8) a = 32'd1280 + 32'd4 * $urandom_range(0, 100);
            else               a = 32'd1024 - 32'd4 * $urandom_range(1, 50);
            op = $urandom_range(0, 2);
            w = (op != 1);
            r = (op != 0);
            d = $urandom;
            model32(w, r, a, d, eo, ee);
            run32(w, r, a, d, lat, o, e, g);
            n_checks++;
            if (lat !== WAIT + 1 || o !== eo || e !== ee || g !== 0) begin
                n_fail++;
                $display("FAIL random_%0d w=%b r=%b addr=%0d: lat=%0d out=%h err=%b glitch=%0d, expected lat=%0d out=%h err=%b",
                         i, w, r, a, lat, o, e, g, WAIT + 1, eo, ee);
            end
        end
    endtask

    task automatic test_wide();
        int lat;
        logic [63:0] o, eo, d;
        logic e, ee;
        logic [31:0] addrs [6];
        logic        wr    [6];
        addrs = '{32'd1032, 32'd1032, 32'd1036, 32'd1144, 32'd1136, 32'd1024};
        wr    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom};
            model64(wr[i], !wr[i], addrs[i], d, eo, ee);
            run64(wr[i], !wr[i], addrs[i], d, lat, o, e);
            n_checks++;
            if (lat !== 1 || o !== eo || e !== ee) begin
                n_fail++;
                $display("FAIL wide_%0d addr=%0d: lat=%0d out=%h err=%b, expected lat=1 out=%h err=%b",
                         i, addrs[i], lat, o, e, eo, ee);
            end
        end
    endtask

    initial begin
        w_en = 1'b0; r_en = 1'b0; alu_res = 32'd0; val_rm = 32'd0;
        w_en64 = 1'b0; r_en64 = 1'b0; alu64 = 32'd0; val64 = 64'd0;
        do_reset();
        test_reset();
        test_idle();
        test_write_read();
        test_boundaries();
        test_simultaneous();
        test_reset_busy();
        test_random();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
